rv32_data_memory: RTL and testbench
===================================

// Module: rv32_data_memory
// PURPOSE
//  Word-organised data RAM for the single-cycle RV32I core, sitting on the load/store path after the ALU.
//  Synchronous write, combinational read; byte address in, 32-bit word out.
//  Mapped at a configurable base address; accesses outside the window are ignored.
// PARAMETERS
//  BASE   0     byte address of word 0 in the data address map
//  AW     32    address width (bits)
//  DW     32    data width (bits); one word per entry
//  DEPTH  1024  number of DW-bit words (power of two); window = DEPTH*4 bytes
// PORTS
//  clk      in   1   clock; all state changes on rising edge
//  rst_n    in   1   reset, asynchronous, active-low
//  address  in   AW  byte address of access
//  read     in   1   read enable
//  write    in   1   write enable
//  wdata    in   DW  write data
//  rdata    out  DW  read data
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-low (rst_n).
//  - While rst_n=0, every word is cleared to 0, and writes are blocked.
//  - Word index:
//    - off = address - BASE (AW-bit unsigned, wraps).
//    - idx = off[log2(DEPTH)+1:2].
//    - off[1:0] ignored: unaligned addresses alias to the containing word.
//  - In range: off < DEPTH*4. Anything else is out of range.
//  - Write: at the rising clk edge, if rst_n=1, write=1 and in range, then mem[idx] <= wdata (full word, no byte lanes).
//  - Out-of-range writes are dropped silently.
//  - Read: purely combinational, zero latency.
//    - rdata = (read & in range) ? mem[idx] : 0.
//    - rdata changes as soon as address or read change.
//  - Read and write to the same word in one cycle: rdata shows the pre-edge content, then the new data after the edge.
//  - read=1 and write=1 together is legal; both act as above.
//  - rdata = 0 during reset and whenever read=0.
// CONFIGURATION
//  DMEM_ERR_EN
//   - Defined:
//     - Adds output port `err`, 1 bit.
//     - err=1 combinationally when (read|write)=1 and the access is out of range or address[1:0]!=0.
//     - Otherwise err=0; err=0 during reset.
//     - Writes and reads behave exactly as without the macro; misaligned accesses still alias to the word.
//   - Undefined: no err port and no error logic.
// TESTING
//  - Reset: pulse rst_n low, then read=1 at addr 0, 4 and 4092 -> rdata=0 for each.
//  - Write/read: write 7 to addr 100 in cycle N; in cycle N+1 set read=1, addr 100 -> rdata=7 before the next edge.
//  - Alias: write 0xDEADBEEF to addr 8; read addr 9, 10, 11 -> all 0xDEADBEEF. With DMEM_ERR_EN, err=1 on each.
//  - Range: write 5 to addr 4096 (DEPTH*4) -> dropped; read addr 0 -> 0; read addr 4096 -> rdata=0 (err=1 with DMEM_ERR_EN).
//  - Same-cycle RAW: mem[12]=3; drive read=1, write=1, wdata=9 at addr 12 -> rdata=3 before the edge, 9 after it.
//  - Random: 10 write-then-read pairs, data 0..9, addr 0..1023, each on its own edge -> readback equals written data.

Source files
------------

// File: rtl/rv32_data_memory.sv
// ---------------------------------------------------------------------------
// rv32_data_memory
//
// Word-organised data RAM for the single-cycle RV32I core. It sits on the
// load/store path after the ALU: synchronous full-word write, combinational
// zero-latency read, byte address in and 32-bit word out.
//
// The RAM occupies a window of DEPTH*4 bytes starting at byte address BASE.
// Accesses outside that window are ignored: writes are dropped and reads
// return zero. The two low address bits are ignored, so an unaligned address
// selects the word that contains it.
//
// Optional feature macro: DMEM_ERR_EN
//   When defined, an extra output `err` flags any active access (read or
//   write) that is out of range or not word aligned. Data behaviour is
//   identical with or without the macro.
//
// Parameters
//   BASE   byte address of word 0
//   AW     address width in bits
//   DW     data width in bits (one word per entry)
//   DEPTH  number of words, power of two
//
// Ports
//   clk      in   1    clock, state changes on the rising edge
//   rst_n    in   1    asynchronous active-low reset; clears every word
//   address  in   AW   byte address of the access
//   read     in   1    read enable
//   write    in   1    write enable
//   wdata    in   DW   write data
//   rdata    out  DW   read data, zero when not reading or out of range
//   err      out  1    (DMEM_ERR_EN only) out-of-range or misaligned access
// ---------------------------------------------------------------------------
module rv32_data_memory #(
   parameter int unsigned       AW    = 32,
   parameter logic [AW-1:0]     BASE  = {AW{1'b0}},
   parameter int unsigned       DW    = 32,
   parameter int unsigned       DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] address,
   input  logic          read,
   input  logic          write,
   input  logic [DW-1:0] wdata,
`ifdef DMEM_ERR_EN
   output logic          err,
`endif
   output logic [DW-1:0] rdata
);

   // Number of word-index bits; the byte offset adds two more below them.
   localparam int unsigned IW = $clog2(DEPTH);

   logic [DW-1:0] mem_r [0:DEPTH-1];

   logic [AW-1:0] off_s;
   logic [IW-1:0] idx_s;
   logic          in_range_s;
   logic          unused_bits_s;

   // Offset from the window base; subtraction wraps so addresses below BASE
   // land far above the window and fail the range test.
   assign off_s = address - BASE;

   // Word index; byte-offset bits are dropped so unaligned addresses alias.
   assign idx_s = off_s[IW+1:2];

   // In range exactly when every offset bit above the window is zero,
   // i.e. off < DEPTH*4.
   assign in_range_s = (off_s[AW-1:IW+2] == {(AW-IW-2){1'b0}});

   // Byte-offset bits of the offset play no part in the data path.
   assign unused_bits_s = ^off_s[1:0];

   // Storage: cleared while reset is asserted, full-word write otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
      end else if (write && in_range_s) begin
         mem_r[idx_s] <= wdata;
      end
   end

   // Combinational read port; forced to zero in reset, when idle, or when
   // the address falls outside the window.
   always_comb begin
      rdata = {DW{1'b0}};
      if (rst_n && read && in_range_s) begin
         rdata = mem_r[idx_s];
      end else begin
         rdata = {DW{1'b0}};
      end
   end

`ifdef DMEM_ERR_EN
   // Access error flag: any active access that misses the window or is not
   // word aligned. The access itself still proceeds as usual.
   always_comb begin
      err = 1'b0;
      if (rst_n && (read || write)) begin
         err = (!in_range_s) || (address[1:0] != 2'b00);
      end else begin
         err = 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_rv32_data_memory.sv
// ---------------------------------------------------------------------------
// tb_rv32_data_memory
//
// Self-checking bench for rv32_data_memory. A word-array model derived from
// the address-window rules predicts rdata (and err when DMEM_ERR_EN is
// defined); a compare process checks the DUT against it on every falling
// clock edge. Directed sequences add hand-computed literal expectations.
// Inputs change 2 time units after the falling edge.
// ---------------------------------------------------------------------------
module tb_rv32_data_memory;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'd0;
   localparam logic [31:0] WIN   = 32'd4096;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        read    = 1'b0;
   logic        write   = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] wdata   = 32'd0;
   logic [31:0] rdata;
`ifdef DMEM_ERR_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   logic [31:0] model [0:DEPTH-1];

   rv32_data_memory #(
      .AW(32), .BASE(BASE), .DW(32), .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .address(address),
      .read(read),
      .write(write),
      .wdata(wdata),
`ifdef DMEM_ERR_EN
      .err(err),
`endif
      .rdata(rdata)
   );

   always #5 clk = ~clk;

   function automatic bit in_window(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < WIN;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic rd, input logic rn);
      if (!rn || !rd || !in_window(a)) return 32'd0;
      return model[(a - BASE) / 32'd4];
   endfunction

   function automatic logic model_err(input logic [31:0] a, input logic rd, input logic wr, input logic rn);
      if (!rn || !(rd || wr)) return 1'b0;
      return !in_window(a) || (a % 32'd4 != 32'd0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model state: cleared by reset, written on the rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
         armed = 1'b1;
      end else if (armed && write && in_window(address)) begin
         model[(address - BASE) / 32'd4] = wdata;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (armed) begin
         check("cycle_rdata", rdata, model_rdata(address, read, rst_n));
`ifdef DMEM_ERR_EN
         check("cycle_err", {31'd0, err}, {31'd0, model_err(address, read, write, rst_n)});
`endif
      end
   end

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      #2;
      read    = rd;
      write   = wr;
      address = a;
      wdata   = d;
   endtask

   task automatic check_err(input string name, input logic exp);
`ifdef DMEM_ERR_EN
      check(name, {31'd0, err}, {31'd0, exp});
`else
      if (exp === 1'bx) $display("unexpected err expectation %s", name);
`endif
   endtask

   initial begin
      logic [31:0] a;

      // Reset; a write attempted during reset must be blocked.
      #3 rst_n = 1'b0;
      drive(1'b1, 1'b1, 32'd0, 32'h0000_0055);
      #1 check("reset_rdata", rdata, 32'd0);
      check_err("reset_err", 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      read  = 1'b0;
      write = 1'b0;

      drive(1'b1, 1'b0, 32'd0, 32'd0);
      #1 check("post_reset_0", rdata, 32'd0);
      drive(1'b1, 1'b0, 32'd4, 32'd0);
      #1 check("post_reset_4", rdata, 32'd0);
      drive(1'b1, 1'b0, 32'd4092, 32'd0);
      #1 check("post_reset_4092", rdata, 32'd0);

      // Write then read next cycle.
      drive(1'b0, 1'b1, 32'd100, 32'd7);
      drive(1'b1, 1'b0, 32'd100, 32'd0);
      #1 check("wr_rd_100", rdata, 32'd7);
      check_err("wr_rd_100_err", 1'b0);

      // Unaligned aliasing.
      drive(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF);
      for (int k = 9; k <= 11; k++) begin
         drive(1'b1, 1'b0, 32'(k), 32'd0);
         #1 check("alias", rdata, 32'hDEAD_BEEF);
         check_err("alias_err", 1'b1);
      end

      // Out-of-range write is dropped and must not wrap into word 0.
      drive(1'b0, 1'b1, 32'd4096, 32'd5);
      check_err("range_wr_err", 1'b1);
      drive(1'b1, 1'b0, 32'd0, 32'd0);
      #1 check("range_addr0", rdata, 32'd0);
      drive(1'b1, 1'b0, 32'd4096, 32'd0);
      #1 check("range_addr4096", rdata, 32'd0);
      check_err("range_rd_err", 1'b1);

      // Last word of the window.
      drive(1'b0, 1'b1, 32'd4092, 32'hA5A5_0001);
      drive(1'b1, 1'b0, 32'd4092, 32'd0);
      #1 check("last_word", rdata, 32'hA5A5_0001);
      check_err("last_word_err", 1'b0);

      // Same-cycle read and write to one word.
      drive(1'b0, 1'b1, 32'd12, 32'd3);
      drive(1'b1, 1'b1, 32'd12, 32'd9);
      #1 check("raw_before", rdata, 32'd3);
      @(posedge clk);
      #1 check("raw_after", rdata, 32'd9);

      // read=0 gives zero even for a populated word.
      drive(1'b0, 1'b0, 32'd12, 32'd0);
      #1 check("read_low", rdata, 32'd0);

      // Write-then-read pairs at pseudo-random addresses.
      for (int i = 0; i < 10; i++) begin
         a = 32'($urandom_range(0, 1023));
         drive(1'b0, 1'b1, a, 32'(i));
         drive(1'b1, 1'b0, a, 32'd0);
         #1 check("pair", rdata, 32'(i));
      end

      drive(1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
